// File: rtl/even_odd_pkg.sv
// even_odd_pkg: class encodings, default sizes and pointer-width helper for the even/odd scheduler
package even_odd_pkg;
    localparam logic CLS_EVEN = 1'b0;
    localparam logic CLS_ODD = 1'b1;
    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/parity_queue.sv
// parity_queue: DATA_W x DEPTH circular FIFO with wrap-bit pointers, no write-to-read bypass
module parity_queue
    import even_odd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/even_odd_scheduler.sv
// even_odd_scheduler: splits samples by LSB into two queues and drains them round-robin
// through a registered output; acceptance counters exist only when EVEN_ODD_STATS_EN is defined
module even_odd_scheduler
    import even_odd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_odd,
    output logic [CNT_W-1:0]  even_cnt,
    output logic [CNT_W-1:0]  odd_cnt,
    output logic              even_full,
    output logic              odd_full
);
    logic [DATA_W-1:0] e_dout, o_dout;
    logic e_empty, o_empty, push_e, push_o, pop_e, pop_o, load, any, sel, last_grant;
    assign in_ready = ~even_full & ~odd_full;
    assign push_e = in_valid & in_ready & (in_data[0] == CLS_EVEN);
    assign push_o = in_valid & in_ready & (in_data[0] == CLS_ODD);
    assign load = ~out_valid | out_ready;
    assign any = ~e_empty | ~o_empty;
    // on a tie the class not granted last time wins
    assign sel = (~e_empty & ~o_empty) ? ~last_grant : (o_empty ? CLS_EVEN : CLS_ODD);
    assign pop_e = load & any & (sel == CLS_EVEN);
    assign pop_o = load & any & (sel == CLS_ODD);
    parity_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_even (
        .clk(clk), .rst_n(rst_n), .push(push_e), .pop(pop_e), .din(in_data),
        .dout(e_dout), .full(even_full), .empty(e_empty)
    );
    parity_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_odd (
        .clk(clk), .rst_n(rst_n), .push(push_o), .pop(pop_o), .din(in_data),
        .dout(o_dout), .full(odd_full), .empty(o_empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_odd <= 1'b0;
            last_grant <= CLS_ODD;
        end else if (load) begin
            out_valid <= any;
            if (any) begin
                out_data <= sel ? o_dout : e_dout;
                out_odd <= sel;
                last_grant <= sel;
            end
        end
    end
`ifdef EVEN_ODD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            even_cnt <= '0;
            odd_cnt <= '0;
        end else begin
            if (push_e && even_cnt != '1) even_cnt <= even_cnt + 1'b1;
            if (push_o && odd_cnt != '1) odd_cnt <= odd_cnt + 1'b1;
        end
    end
`else
    assign even_cnt = '0;
    assign odd_cnt = '0;
`endif
endmodule

// File: tb/tb_even_odd_scheduler.sv
// tb_even_odd_scheduler: directed checks of latency, arbitration order, backpressure, counters and reset
module tb_even_odd_scheduler;
    localparam int CNT_W = 2;
`ifdef EVEN_ODD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_odd, even_full, odd_full;
    logic [3:0] in_data = '0, out_data;
    logic [CNT_W-1:0] even_cnt, odd_cnt;
    int n_cmp = 0, n_err = 0;
    int got[$];
    int e[$];
    logic prev_stall = 1'b0;
    int prev_out = 0;
    always #5 clk = ~clk;
    even_odd_scheduler #(.DATA_W(4), .DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_odd(out_odd),
        .even_cnt(even_cnt), .odd_cnt(odd_cnt), .even_full(even_full), .odd_full(odd_full)
    );
    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [3:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
    endtask
    task automatic chk_q(input string tag);
        chk({tag, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk(tag, (i < got.size()) ? got[i] : -1, e[i]);
    endtask
    task automatic lat_check(input logic [3:0] d);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = d;
        step();
        in_valid = 1'b0;
        chk("lat_n1_valid", int'(out_valid), 0);
        step();
        chk("lat_n2_valid", int'(out_valid), 1);
        chk("lat_n2_data", int'(out_data), int'(d));
        chk("lat_n2_odd", int'(out_odd), int'(d[0]));
        step();
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask
    // every handshake is logged as {odd,data}; a stalled cycle must not change the output
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got.push_back(int'({out_odd, out_data}));
        if (rst_n && prev_stall) chk("hold", int'({out_valid, out_odd, out_data}), prev_out);
        prev_stall <= rst_n && out_valid && !out_ready;
        prev_out <= int'({out_valid, out_odd, out_data});
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        step();
        step();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_odd", int'(out_odd), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_even_full", int'(even_full), 0);
        chk("rst_odd_full", int'(odd_full), 0);
        chk("rst_even_cnt", int'(even_cnt), 0);
        chk("rst_odd_cnt", int'(odd_cnt), 0);
        rst_n = 1'b1;
        step();
        lat_check(4'd6);
        chk("single_even_cnt", int'(even_cnt), STATS ? 1 : 0);
        got.delete();
        out_ready = 1'b0;
        send(4'd2); send(4'd4); send(4'd1); send(4'd3);
        out_ready = 1'b1;
        repeat (6) step();
        e = '{2, 17, 4, 19};
        chk_q("rr_order");
        got.delete();
        out_ready = 1'b0;
        in_valid = 1'b1;
        begin
            int n;
            n = 0;
            for (int i = 0; i < 8; i++) begin
                logic acc;
                in_data = 4'(2 * n);
                acc = in_ready;
                step();
                if (acc) n++;
            end
            chk("fill_accepted", n, 5);
        end
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_even_full", int'(even_full), 1);
        in_data = 4'd5;
        step();
        step();
        chk("odd_stalled_ready", int'(in_ready), 0);
        chk("odd_stalled_full", int'(odd_full), 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) step();
        send(4'd5);
        repeat (3) step();
        e = '{0, 2, 4, 6, 8, 21};
        chk_q("full_drain");
        got.delete();
        fork
            begin
                send(4'd3); send(4'd8); send(4'd5); send(4'd10); send(4'd7); send(4'd12);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    out_ready = i[0];
                    step();
                end
            end
        join
        out_ready = 1'b1;
        repeat (8) step();
        begin
            int ev[$];
            int od[$];
            foreach (got[i]) if (got[i] >= 16) od.push_back(got[i] - 16); else ev.push_back(got[i]);
            chk("toggle_even_len", ev.size(), 3);
            chk("toggle_odd_len", od.size(), 3);
            e = '{8, 10, 12};
            foreach (e[i]) chk("toggle_even", (i < ev.size()) ? ev[i] : -1, e[i]);
            e = '{3, 5, 7};
            foreach (e[i]) chk("toggle_odd", (i < od.size()) ? od[i] : -1, e[i]);
        end
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(4'(2 * i + 1));
            chk("odd_cnt_sat", int'(odd_cnt), STATS ? ((i + 1 > 3) ? 3 : i + 1) : 0);
        end
        repeat (4) step();
        got.delete();
        out_ready = 1'b0;
        send(4'd2); send(4'd1); send(4'd4); send(4'd3);
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_even_cnt", int'(even_cnt), STATS ? 2 : 0);
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_data", int'(out_data), 0);
        chk("async_rst_in_ready", int'(in_ready), 1);
        chk("async_rst_even_cnt", int'(even_cnt), 0);
        chk("async_rst_odd_cnt", int'(odd_cnt), 0);
        step();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        chk("flushed_valid", int'(out_valid), 0);
        chk("flushed_none", got.size(), 0);
        lat_check(4'd6);
        e = '{6};
        chk_q("post_rst");
        chk("post_rst_even_cnt", int'(even_cnt), STATS ? 1 : 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
